serial_frame_rx: RTL and testbench
==================================

# serial_frame_rx

Receive-side framing stage that consumes the one-bit-per-strobe stream produced by the team's serializer (PISO) path and rebuilds parallel words. It hunts for a start bit, shifts in WIDTH data bits LSB first, checks even parity and the stop bit, then presents the word through a single-entry valid/ready output buffer. It sits directly downstream of the transmit shift register and feeds the word-level consumer logic.

## Interface
Parameters:
- WIDTH, 32, data bits per frame (≥2)

Ports:
- clk  input  1  system clock, all state updates on posedge
- rst_b  input  1  synchronous, active-high reset (1 = reset, sampled on posedge clk)
- inb  input  1  serial line bit, meaningful only when bit_en = 1
- bit_en  input  1  sample strobe; exactly one line bit consumed per cycle with bit_en = 1
- data_out  output  WIDTH  received word, stable while data_valid = 1
- data_valid  output  1  output buffer holds an unconsumed word
- data_ready  input  1  consumer accepts word this cycle
- parity_err  output  1  parity flag for the word in data_out, qualified by data_valid
- frame_err  output  1  one-cycle pulse: bad stop bit, frame discarded
- overrun  output  1  sticky: completed frame dropped because buffer was full; cleared only by reset

## Operation
- Frame on the line: idle = 0; start bit = 1; WIDTH data bits, LSB first; parity bit making the count of 1s across data+parity even; stop bit = 0.
- FSM states: IDLE, DATA, PARITY, STOP. Transitions occur only on cycles with bit_en = 1; bit_en = 0 holds all state.
- IDLE: inb = 1 → DATA, bit counter cleared, parity accumulator cleared. inb = 0 → stay.
- DATA: shift inb into MSB of shift register (right shift), XOR into parity accumulator, increment counter; after WIDTH-th bit → PARITY. Counter width $clog2(WIDTH)+1; no wrap inside a frame.
- PARITY: capture parity result (accumulator XOR inb; 1 = error) → STOP.
- STOP: inb = 0 → frame good; inb = 1 → frame_err pulse, frame discarded, buffer untouched. Either case → IDLE (a stop bit of 1 is not reused as a start bit).
- Good frame, buffer empty or being drained this cycle (data_valid & data_ready): load data_out, parity_err, set data_valid.
- Good frame, buffer full and not drained this cycle: frame dropped, overrun set, data_out/parity_err unchanged.
- Handshake: transfer when data_valid & data_ready at posedge; data_valid clears next cycle unless a new frame loads the same cycle. data_ready with data_valid = 0 has no effect.
- Parity errors do not drop the word; consumer decides.

## Timing
- Reset values: FSM = IDLE, counter = 0, shift register = 0, data_out = 0, data_valid = 0, parity_err = 0, frame_err = 0, overrun = 0.
- Reset mid-frame: partial frame discarded, buffered word discarded, next start bit searched from IDLE on the first strobe after reset deasserts.
- Latency: data_valid rises on the posedge after the clock edge that samples the stop bit (registered output).
- Minimum frame = WIDTH+3 strobes; back-to-back frames (start bit on the strobe right after stop) must be received.
- frame_err is high for exactly one cycle, on the cycle following the bad stop-bit sample.
- All outputs registered; no combinational path from inb/bit_en/data_ready to any output.

## Test plan
Bench uses WIDTH = 8.
- Reset then bit_en = 1 every cycle, frame 1,0x5A LSB first (0,1,0,1,1,0,1,0),parity 0,stop 0 → data_out = 0x5A, data_valid = 1, parity_err = 0 one cycle after stop sample; holds with data_ready = 0.
- Same frame with parity bit 1 → data_out = 0x5A, parity_err = 1; data_ready = 1 → data_valid = 0 next cycle.
- bit_en toggling 1/0 each cycle during frame 0xC3 → identical result to continuous strobe, just 2× slower; no bits duplicated or lost.
- Two back-to-back frames 0x11 then 0x22, data_ready = 0 throughout → first word 0x11 retained, overrun = 1 after second stop; then data_ready pulse pulled on the exact completion cycle of a third frame 0x33 → 0x33 loads, overrun stays 1.
- Frame 0x7E with stop bit 1 → frame_err one-cycle pulse, data_valid stays 0, FSM back in IDLE; following valid frame 0x01 received correctly.
- rst_b = 1 asserted after 4 data bits of frame 0xFF with a buffered word present → all outputs return to reset values; next full frame 0x0F received correctly.

Source files
------------

// File: rtl/serial_frame_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_frame_rx_if
//  Description : Serial-line input and word-level valid/ready output bundle
//                for the framing receiver.
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_frame_rx_if #(
    parameter int WIDTH = 32
) ();
    logic             inb;
    logic             bit_en;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;
    logic             parity_err;
    logic             frame_err;
    logic             overrun;

    // Upstream driver and word consumer side
    modport master (
        output inb,
        output bit_en,
        output data_ready,
        input  data_out,
        input  data_valid,
        input  parity_err,
        input  frame_err,
        input  overrun
    );

    // Receiver side
    modport slave (
        input  inb,
        input  bit_en,
        input  data_ready,
        output data_out,
        output data_valid,
        output parity_err,
        output frame_err,
        output overrun
    );
endinterface
`default_nettype wire

// File: rtl/serial_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_frame_rx
//  Description : Start-bit hunting serial frame receiver. Shifts in WIDTH
//                data bits LSB first, checks even parity and the stop bit,
//                and holds the word in a single-entry valid/ready buffer.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_frame_rx #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_b,
    serial_frame_rx_if.slave   bus
);

    localparam int                   c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0]   c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_shift;
    logic               r_par_acc;
    logic               r_par_bad;
    logic [WIDTH-1:0]   r_data_out;
    logic               r_data_valid;
    logic               r_parity_err;
    logic               r_frame_err;
    logic               r_overrun;

    // Consumer takes the buffered word at this edge
    logic w_drain;
    // Buffer can accept a finished frame this edge (empty, or emptying now)
    logic w_can_load;

    assign w_drain    = r_data_valid & bus.data_ready;
    assign w_can_load = ~r_data_valid | bus.data_ready;

    // Frame FSM, shift/parity datapath and output buffer; every output is a flop
    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_par_acc    <= 1'b0;
            r_par_bad    <= 1'b0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;

            // A load below in the same cycle overrides this clear
            if (w_drain) begin
                r_data_valid <= 1'b0;
            end

            if (bus.bit_en) begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.inb) begin
                            r_state   <= S_DATA;
                            r_cnt     <= '0;
                            r_par_acc <= 1'b0;
                        end
                    end
                    S_DATA: begin
                        // Right shift: after WIDTH bits the first (LSB) bit sits at bit 0
                        r_shift   <= {bus.inb, r_shift[WIDTH-1:1]};
                        r_par_acc <= r_par_acc ^ bus.inb;
                        r_cnt     <= r_cnt + c_CNT_W'(1);
                        if (r_cnt == c_LAST) begin
                            r_state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        // Even parity over data+parity: any residual 1 is an error
                        r_par_bad <= r_par_acc ^ bus.inb;
                        r_state   <= S_STOP;
                    end
                    S_STOP: begin
                        if (!bus.inb) begin
                            if (w_can_load) begin
                                r_data_out   <= r_shift;
                                r_parity_err <= r_par_bad;
                                r_data_valid <= 1'b1;
                            end else begin
                                r_overrun    <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                        // A bad stop bit of 1 is never reused as the next start bit
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_data_valid;
    assign bus.parity_err = r_parity_err;
    assign bus.frame_err  = r_frame_err;
    assign bus.overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_frame_rx
//  Description : Self-checking bench for serial_frame_rx (WIDTH = 8). The
//                driver builds line frames and pushes expected words into a
//                scoreboard; a negedge monitor compares DUT outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_frame_rx;

    localparam int c_W = 8;

    logic clk;
    logic rst_b;

    serial_frame_rx_if #(.WIDTH(c_W)) u_if ();

    serial_frame_rx #(.WIDTH(c_W)) u_dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: {parity_err, word} of the word the buffer should hold
    logic [8:0] exp_q[$];
    logic       exp_ovr;
    logic       exp_ferr;
    bit         mon_en;
    int         n_checks;
    int         n_fail;
    logic [7:0] cur_word;
    logic       cur_perr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; kind 1 = good stop strobe, 2 = bad stop strobe
    task automatic drive(input logic b, input logic en, input logic rdy, input int kind);
        u_if.inb        = b;
        u_if.bit_en     = en;
        u_if.data_ready = rdy;
        @(posedge clk);
        exp_ferr = 1'b0;
        if (en && kind == 1) begin
            // Monitor already popped a word the consumer took at this edge
            if (exp_q.size() == 0) exp_q.push_back({cur_perr, cur_word});
            else                   exp_ovr = 1'b1;
        end
        if (en && kind == 2) exp_ferr = 1'b1;
        #1;
    endtask

    function automatic logic pick_rdy(input int mode, input bit at_stop);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return 1'($urandom_range(0, 1));
            default: return at_stop ? 1'b1 : 1'b0;
        endcase
    endfunction

    // gap_mode: 0 continuous, 1 strobe every other cycle, 2 random gaps
    // rdy_mode: 0 never, 1 always, 2 random, 3 only on the stop strobe
    task automatic send_frame(input logic [7:0] w, input logic bad_par, input logic stop_bit,
                              input int gap_mode, input int rdy_mode);
        logic [10:0] bits;
        bits     = {stop_bit, (^w) ^ bad_par, w, 1'b1};
        cur_word = w;
        cur_perr = bad_par;
        for (int i = 0; i < 11; i++) begin
            if (gap_mode == 2) begin
                int g;
                g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++)
                    drive(1'($urandom_range(0, 1)), 1'b0, pick_rdy(rdy_mode, 1'b0), 0);
            end
            drive(bits[i], 1'b1, pick_rdy(rdy_mode, i == 10),
                  (i == 10) ? (stop_bit ? 2 : 1) : 0);
            if (gap_mode == 1)
                drive(1'($urandom_range(0, 1)), 1'b0, pick_rdy(rdy_mode, 1'b0), 0);
        end
    endtask

    // inb/bit_en held active during reset to show reset dominates
    task automatic do_reset(input int n);
        rst_b           = 1'b1;
        u_if.inb        = 1'b1;
        u_if.bit_en     = 1'b1;
        u_if.data_ready = 1'b0;
        @(posedge clk);
        exp_q.delete();
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
        mon_en   = 1'b1;
        repeat (n - 1) @(posedge clk);
        #1;
        rst_b       = 1'b0;
        u_if.inb    = 1'b0;
        u_if.bit_en = 1'b0;
    endtask

    // Monitor: compares registered outputs away from the active edge
    always @(negedge clk) begin
        if (mon_en) begin
            chk("data_valid", 32'(u_if.data_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("data_out",   32'(u_if.data_out),   32'(exp_q[0][7:0]));
                chk("parity_err", 32'(u_if.parity_err), 32'(exp_q[0][8]));
                if (u_if.data_ready) void'(exp_q.pop_front());
            end
            chk("frame_err", 32'(u_if.frame_err), 32'(exp_ferr));
            chk("overrun",   32'(u_if.overrun),   32'(exp_ovr));
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mon_en   = 1'b0;
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
        cur_word = '0;
        cur_perr = 1'b0;
        rst_b    = 1'b1;
        u_if.inb = 1'b0; u_if.bit_en = 1'b0; u_if.data_ready = 1'b0;

        do_reset(3);
        @(negedge clk);
        chk("reset_data_out",   32'(u_if.data_out),   32'h0);
        chk("reset_parity_err", 32'(u_if.parity_err), 32'h0);
        #1;

        // Good frame, held with no consumer
        send_frame(8'h5A, 1'b0, 1'b0, 0, 0);
        repeat (3) drive(1'b0, 1'b1, 1'b0, 0);
        drive(1'b0, 1'b1, 1'b1, 0);
        drive(1'b0, 1'b1, 1'b0, 0);

        // Parity error frame, then drained
        send_frame(8'h5A, 1'b1, 1'b0, 0, 0);
        drive(1'b0, 1'b1, 1'b1, 0);
        drive(1'b0, 1'b1, 1'b0, 0);

        // Strobe toggling every other cycle
        send_frame(8'hC3, 1'b0, 1'b0, 1, 0);
        drive(1'b0, 1'b1, 1'b1, 0);
        drive(1'b0, 1'b1, 1'b0, 0);

        // Back-to-back frames with full buffer, then drain exactly at completion
        send_frame(8'h11, 1'b0, 1'b0, 0, 0);
        send_frame(8'h22, 1'b0, 1'b0, 0, 0);
        drive(1'b0, 1'b1, 1'b0, 0);
        send_frame(8'h33, 1'b0, 1'b0, 0, 3);
        drive(1'b0, 1'b1, 1'b0, 0);
        drive(1'b0, 1'b1, 1'b1, 0);
        drive(1'b0, 1'b1, 1'b0, 0);

        // Bad stop bit, then a good frame straight after
        send_frame(8'h7E, 1'b0, 1'b1, 0, 0);
        send_frame(8'h01, 1'b0, 1'b0, 0, 0);
        drive(1'b0, 1'b1, 1'b1, 0);
        drive(1'b0, 1'b1, 1'b0, 0);

        // Reset mid-frame with a buffered word present
        send_frame(8'hA5, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 0);
        do_reset(2);
        @(negedge clk);
        chk("midrst_data_out",   32'(u_if.data_out),   32'h0);
        chk("midrst_parity_err", 32'(u_if.parity_err), 32'h0);
        #1;
        send_frame(8'h0F, 1'b0, 1'b0, 0, 0);
        drive(1'b0, 1'b1, 1'b1, 0);
        drive(1'b0, 1'b1, 1'b0, 0);

        // Randomized traffic; fresh reset so overrun starts clear
        do_reset(2);
        for (int f = 0; f < 40; f++) begin
            int idle;
            send_frame(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                       2 * int'($urandom_range(0, 1)), 2);
            idle = $urandom_range(0, 2);
            for (int k = 0; k < idle; k++)
                drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end
        repeat (3) drive(1'b0, 1'b1, 1'b1, 0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
